mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage consumer of the E/M pipeline register outputs. Turns opcode/funct3/ALUResultM/rdata2M
//  into a data-memory transaction (req/gnt/rvalid handshake), then sign/zero-extends load data.
//  Raises stall_mem while an access is outstanding so upstream pipeline registers hold.
//  Flags misaligned or illegal-funct3 accesses instead of issuing them.
// PARAMETERS
//  ADDR_W     32           address width of ALUResultM and dmem_addr
//  LOAD_OPC   7'b0000011   opcode decoded as load
//  STORE_OPC  7'b0100011   opcode decoded as store
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset (0 = reset)
//  mem_validM     in   1       M-stage slot holds a live instruction
//  instr_opcodeM  in   7       opcode of M-stage instruction
//  funct3M        in   3       access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  ALUResultM     in   ADDR_W  effective byte address
//  rdata2M        in   32      store data (rs2)
//  dmem_req       out  1       request valid; held until dmem_gnt
//  dmem_we        out  1       1 = store, 0 = load
//  dmem_addr      out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata     out  32      lane-replicated store data
//  dmem_wstrb     out  4       byte enables (store only, 0 for loads)
//  dmem_gnt       in   1       memory accepted request this cycle
//  dmem_rvalid    in   1       load data valid on dmem_rdata
//  dmem_rdata     in   32      load word
//  stall_mem      out  1       hold upstream stages
//  load_dataM     out  32      extended load result (registered, holds last value)
//  load_validM    out  1       one-cycle pulse: load_dataM freshly updated
//  access_exc     out  1       misaligned/illegal access detected (combinational, IDLE only)
// BEHAVIOUR
//  - memop = mem_validM & (opcode==LOAD_OPC | opcode==STORE_OPC). Non-memop: no request, no stall.
//  - Illegal: misaligned halfword when addr[0]=1; misaligned word when addr[1:0]!=0;
//    store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}.
//    Illegal memop in IDLE -> access_exc=1 same cycle, no request, no stall.
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - IDLE, legal memop:
//    - dmem_req=1 combinationally; addr/we/wdata/wstrb/funct3/addr[1:0] are latched into internal regs.
//    - gnt & store -> stay IDLE, stall_mem=0 (single-cycle store).
//    - gnt & load -> WAIT, stall_mem=1.
//    - no gnt -> REQ, stall_mem=1.
//  - REQ: drive dmem_* from the latched regs with dmem_req=1; stall_mem=1.
//    - gnt: store -> IDLE, stall_mem=0 this cycle; load -> WAIT.
//  - WAIT: dmem_req=0, stall_mem=1. On dmem_rvalid: capture extended data into load_dataM -> DONE.
//    - rvalid is ignored in all other states.
//  - DONE: stall_mem=0, load_validM=1 for exactly this cycle -> IDLE.
//    - The new M instruction is not examined until IDLE.
//  - Load latency with gnt in the issue cycle and rvalid on the next cycle:
//    - stall_mem high for 2 cycles; load_validM in the 3rd cycle.
//  - Store lanes:
//    - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
//    - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
//    - SW: wdata=rs2, wstrb=4'b1111.
//  - Load extract: byte/half selected by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//  - Reset (async, any state): state=IDLE; dmem_req, dmem_we, dmem_wstrb, stall_mem, load_validM, access_exc = 0;
//    dmem_addr, dmem_wdata, load_dataM = 0.
//    - An in-flight access is abandoned; a later stray rvalid is ignored.
// TESTING
//  - SW rs2=0xDEADBEEF addr=0x100, gnt same cycle -> wstrb=1111, addr=0x100, stall_mem never 1.
//  - SB rs2=0x000000A5 addr=0x103, gnt delayed 3 cycles -> wdata=0xA5A5A5A5, wstrb=1000.
//    - req and fields held stable; stall_mem=1 for 3 cycles.
//  - LB addr=0x202, rdata=0x00F0_0000, rvalid 1 cycle after gnt -> load_dataM=0xFFFF_FFF0.
//    - load_validM pulse 1 cycle; stall 2 cycles.
//  - LHU addr=0x202, rdata=0x8001_0000 -> 0x0000_8001; LH same -> 0xFFFF_8001.
//  - LW addr=0x101 -> access_exc=1, dmem_req=0, stall_mem=0.
//    - LB with funct3=011 -> access_exc=1.
//  - Assert rst=0 while in WAIT -> all outputs 0 immediately; rvalid after release ignored.
//    - Next LW returns correct data.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer over a req/gnt/rvalid data port.
// It replicates store lanes, sign/zero-extends load data, stalls while busy and flags illegal accesses.
module mem_access_unit #(
  parameter int         ADDR_W    = 32,
  parameter logic [6:0] LOAD_OPC  = 7'b0000011,
  parameter logic [6:0] STORE_OPC = 7'b0100011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_validM,
  input  logic [6:0]        instr_opcodeM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       rdata2M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_mem,
  output logic [31:0]       load_dataM,
  output logic              load_validM,
  output logic              access_exc
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_ld;
  logic              w_is_ld, w_is_st, w_memop, w_align_ok, w_f3_ok, w_legal, w_idle, w_issue;
  logic [ADDR_W-1:0] w_aligned;
  logic [31:0]       w_wdata, w_ext;
  logic [3:0]        w_wstrb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  assign w_is_ld    = mem_validM & (instr_opcodeM == LOAD_OPC);
  assign w_is_st    = mem_validM & (instr_opcodeM == STORE_OPC);
  assign w_memop    = w_is_ld | w_is_st;
  assign w_align_ok = (funct3M[1:0] == 2'b01) ? ~ALUResultM[0] :
                      (funct3M[1:0] == 2'b10) ? (ALUResultM[1:0] == 2'b00) : 1'b1;
  assign w_f3_ok    = w_is_st ? (funct3M inside {3'b000, 3'b001, 3'b010})
                              : (funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_legal    = w_memop & w_f3_ok & w_align_ok;
  assign w_idle     = (r_state == S_IDLE);
  assign w_issue    = w_idle & w_legal;
  assign w_aligned  = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign w_wdata    = (funct3M[1:0] == 2'b00) ? {4{rdata2M[7:0]}} :
                      (funct3M[1:0] == 2'b01) ? {2{rdata2M[15:0]}} : rdata2M;
  assign w_wstrb    = (funct3M[1:0] == 2'b00) ? 4'b0001 << ALUResultM[1:0] :
                      (funct3M[1:0] == 2'b01) ? 4'b0011 << {ALUResultM[1], 1'b0} : 4'b1111;
  assign w_byte     = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_half     = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign w_ext      = (r_f3[1:0] == 2'b00) ? {{24{~r_f3[2] & w_byte[7]}}, w_byte} :
                      (r_f3[1:0] == 2'b01) ? {{16{~r_f3[2] & w_half[15]}}, w_half} : dmem_rdata;
  // Issue cycle drives the port straight from the M stage; later cycles replay the latched copy.
  assign dmem_req    = rst & (w_issue | (r_state == S_REQ));
  assign dmem_we     = dmem_req & (w_idle ? w_is_st : r_we);
  assign dmem_addr   = ~rst ? '0 : w_idle ? w_aligned : r_addr;
  assign dmem_wdata  = ~rst ? '0 : w_idle ? w_wdata : r_wdata;
  assign dmem_wstrb  = {4{dmem_we}} & (w_idle ? w_wstrb : r_wstrb);
  assign stall_mem   = rst & (w_issue ? ~(dmem_gnt & w_is_st) :
                              (r_state == S_REQ) ? ~(dmem_gnt & r_we) : (r_state == S_WAIT));
  assign load_validM = rst & (r_state == S_DONE);
  assign access_exc  = rst & w_idle & w_memop & ~w_legal;
  assign load_dataM  = r_ld;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_ld    <= '0;
    end else begin
      if (w_issue) begin
        r_addr  <= w_aligned;
        r_we    <= w_is_st;
        r_wdata <= w_wdata;
        r_wstrb <= w_is_st ? w_wstrb : 4'b0000;
        r_f3    <= funct3M;
        r_off   <= ALUResultM[1:0];
      end
      case (r_state)
        S_IDLE: if (w_issue) r_state <= dmem_gnt ? (w_is_st ? S_IDLE : S_WAIT) : S_REQ;
        S_REQ:  if (dmem_gnt) r_state <= r_we ? S_IDLE : S_WAIT;
        S_WAIT: if (dmem_rvalid) begin
          r_ld    <= w_ext;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
